// File: rtl/out_port_arbiter.sv
// out_port_arbiter: wormhole round-robin arbiter and zero-latency mux
// for one router output port, plus a wrapping tail-flit counter.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid_i   per-input flit valid          [NUM_IN]
//   in_ready_o   per-input ready, onehot0      [NUM_IN]
//   in_data_i    packed flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid_o  muxed flit valid
//   out_ready_i  downstream ready
//   out_data_o   muxed flit                    [DATA_WIDTH]
//   grant_o      one-hot current grant, 0 when none
//   busy_o       high while a packet holds the lock
//   pkt_cnt_o    tail flits forwarded, wraps   [CNT_WIDTH]
module out_port_arbiter #(
  parameter int          NUM_IN     = 3,
  parameter int          DATA_WIDTH = 32,
  parameter logic [1:0]  TAIL_TYPE  = 2'b11,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_valid_i,
  output logic [NUM_IN-1:0]            in_ready_o,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [NUM_IN-1:0]            grant_o,
  output logic                         busy_o,
  output logic [CNT_WIDTH-1:0]         pkt_cnt_o
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        lock_q;
  logic [IW-1:0]        rr_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [DATA_WIDTH-1:0] din [NUM_IN];
  logic [IW-1:0]         win;
  logic                  any_v;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         sel;
  logic [NUM_IN-1:0]     sel_oh;
  logic                  locked;
  logic                  fire;
  logic                  tail;

  // (a + k) mod NUM_IN, with a < NUM_IN and k < NUM_IN
  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return IW'(s);
  endfunction

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign din[g] = in_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search from rr_q; input 0 when nobody is valid
  always_comb begin
    win   = '0;
    any_v = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = wrap_add(rr_q, k);
      if (!any_v && in_valid_i[idx]) begin
        any_v = 1'b1;
        win   = idx;
      end
    end
  end

  assign locked = (state_q == LOCKED);
  assign sel    = locked ? lock_q : win;
  assign sel_oh = NUM_IN'(1) << sel;

  assign out_data_o  = din[sel];
  assign out_valid_o = ~rst & in_valid_i[sel];
  assign in_ready_o  = rst ? '0
                     : (sel_oh & {NUM_IN{out_ready_i}});
  assign grant_o     = (out_valid_o | locked) ? sel_oh : '0;
  assign busy_o      = locked;
  assign pkt_cnt_o   = cnt_q;

  assign fire = out_valid_o & out_ready_i;
  assign tail = (out_data_o[DATA_WIDTH-1 -: 2] == TAIL_TYPE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_v) begin
            if (fire && tail) begin
              rr_q  <= wrap_add(win, 1);
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else begin
              // freeze the choice so a stalled flit cannot change
              state_q <= LOCKED;
              lock_q  <= win;
            end
          end
        end
        LOCKED: begin
          if (fire && tail) begin
            state_q <= IDLE;
            rr_q    <= wrap_add(lock_q, 1);
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_grant_oh: assert property (
    @(posedge clk) $onehot0(grant_o));

  a_ready_oh: assert property (
    @(posedge clk) $onehot0(in_ready_o));

  a_data_hold: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid_o && !out_ready_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: directed vectors for out_port_arbiter
// (NUM_IN=3, DATA_WIDTH=32, CNT_WIDTH=4 to reach the wrap quickly).
module tb_out_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int CW = 4;

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b00;
  localparam logic [1:0] TL = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    grant;
  logic            busy;
  logic [CW-1:0]   pkt_cnt;

  int errs   = 0;
  int checks = 0;
  int ptr [N];

  out_port_arbiter #(
    .NUM_IN    (N),
    .DATA_WIDTH(DW),
    .TAIL_TYPE (2'b11),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .grant_o    (grant),
    .busy_o     (busy),
    .pkt_cnt_o  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fl(
    input logic [1:0] t,
    input int         p
  );
    return {t, 30'(p)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input int          i,
    input logic        v,
    input logic [31:0] d
  );
    in_valid[i]        = v;
    in_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // 1: reset with all valids high
    for (int i = 0; i < N; i++) set_in(i, 1'b1, fl(TL, i));
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 32'(in_ready), 32'h0);
      chk("rst_ovalid", 32'(out_valid), 32'h0);
      chk("rst_cnt", 32'(pkt_cnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    rst      = 1'b0;
    in_valid = '0;
    #1;
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_data", out_data, fl(TL, 0));

    // 2: 4-flit packet on input 1
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_in(1, 1'b1,
        fl(f == 0 ? HD : (f == 3 ? TL : BD), 16 + f));
      #1;
      chk("t2_valid", 32'(out_valid), 32'h1);
      chk("t2_data", out_data,
        fl(f == 0 ? HD : (f == 3 ? TL : BD), 16 + f));
      chk("t2_grant", 32'(grant), 32'h2);
      chk("t2_ready", 32'(in_ready), 32'h2);
      tick();
    end
    in_valid = '0;
    #1;
    chk("t2_cnt", 32'(pkt_cnt), 32'h1);
    chk("t2_busy", 32'(busy), 32'h0);
    // rr pointer now at 2
    for (int i = 0; i < N; i++) set_in(i, 1'b1, fl(TL, 40 + i));
    #1;
    chk("t2_rr", 32'(grant), 32'h4);
    in_valid = '0;

    // 3: three 2-flit packets, all valid at once
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) ptr[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        set_in(i, ptr[i] < 2,
          fl(ptr[i] == 0 ? HD : TL, i*16 + ptr[i]));
      #1;
      chk("t3_data", out_data,
        fl(c % 2 == 0 ? HD : TL, (c/2)*16 + c % 2));
      chk("t3_grant", 32'(grant), 32'(1 << (c/2)));
      for (int i = 0; i < N; i++)
        if (in_ready[i] && in_valid[i]) ptr[i]++;
      tick();
    end
    for (int i = 0; i < N; i++) set_in(i, 1'b0, 32'h0);
    #1;
    chk("t3_cnt", 32'(pkt_cnt), 32'h3);
    chk("t3_idle", 32'(out_valid), 32'h0);

    // 4: backpressure on input 2's head
    do_reset();
    set_in(2, 1'b1, fl(HD, 32));
    #1;
    chk("t4_data0", out_data, fl(HD, 32));
    chk("t4_grant0", 32'(grant), 32'h4);
    tick();
    set_in(0, 1'b1, fl(TL, 7));
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_hold", out_data, fl(HD, 32));
      chk("t4_grant", 32'(grant), 32'h4);
      chk("t4_noready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_ready", 32'(in_ready), 32'h4);
    tick();
    set_in(2, 1'b1, fl(TL, 33));
    #1;
    chk("t4_tail", out_data, fl(TL, 33));
    chk("t4_grant2", 32'(grant), 32'h4);
    tick();
    set_in(2, 1'b0, 32'h0);
    #1;
    chk("t4_next", 32'(grant), 32'h1);
    chk("t4_ndata", out_data, fl(TL, 7));
    tick();
    set_in(0, 1'b0, 32'h0);
    #1;
    chk("t4_cnt", 32'(pkt_cnt), 32'h2);
    chk("t4_busy", 32'(busy), 32'h0);

    // 5: mid-packet bubble on locked input 0
    do_reset();
    out_ready = 1'b1;
    set_in(0, 1'b1, fl(HD, 1));
    tick();
    set_in(0, 1'b0, fl(BD, 2));
    set_in(1, 1'b1, fl(TL, 9));
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t5_bubble", 32'(out_valid), 32'h0);
      chk("t5_ready", 32'(in_ready), 32'h1);
      chk("t5_grant", 32'(grant), 32'h1);
      chk("t5_busy", 32'(busy), 32'h1);
      tick();
    end
    set_in(0, 1'b1, fl(BD, 2));
    #1;
    chk("t5_resume", out_data, fl(BD, 2));
    tick();
    set_in(0, 1'b1, fl(TL, 3));
    #1;
    chk("t5_tail", out_data, fl(TL, 3));
    tick();
    set_in(0, 1'b0, 32'h0);
    #1;
    chk("t5_next", 32'(grant), 32'h2);
    tick();
    set_in(1, 1'b0, 32'h0);
    #1;
    chk("t5_cnt", 32'(pkt_cnt), 32'h2);

    // 6: counter wrap, then reset aborting a lock
    do_reset();
    out_ready = 1'b1;
    set_in(0, 1'b1, fl(TL, 5));
    for (int c = 0; c < 16; c++) tick();
    chk("t6_wrap0", 32'(pkt_cnt), 32'h0);
    tick();
    chk("t6_wrap1", 32'(pkt_cnt), 32'h1);
    set_in(0, 1'b0, 32'h0);
    set_in(1, 1'b1, fl(HD, 6));
    tick();
    chk("t6_locked", 32'(busy), 32'h1);
    set_in(0, 1'b1, fl(TL, 8));
    rst = 1'b1;
    #1;
    chk("t6_rvalid", 32'(out_valid), 32'h0);
    chk("t6_rready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_abort", 32'(busy), 32'h0);
    chk("t6_restart", 32'(grant), 32'h1);
    chk("t6_rcnt", 32'(pkt_cnt), 32'h0);
    in_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
